uart_rx: RTL and testbench

Serial receive stage of the UART, directly downstream of `uart_baud_gen`. It consumes the 16x-oversample `tick` as its only timing reference and recovers 8-bit asynchronous frames from the `rx` pin: start bit, LSB-first data, optional parity, one stop bit. Received bytes are presented on a valid/ready interface to the register/FIFO layer, with framing and overrun errors flagged as single-cycle pulses.

---
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 16x-oversampled UART receiver with valid/ready byte output,
//               framing/overrun error pulses; optional parity via the
//               UART_RX_PARITY_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun_err
`ifdef UART_RX_PARITY_EN
    ,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic                 parity_err
`endif
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE/2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic [2:0]             r_state;
    logic [2:0]             w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [TW-1:0]          r_tick_cnt;
    logic [BW-1:0]          r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   w_rx_s;
    logic                   w_data_smp;
    logic                   w_stop_smp;
    logic                   w_load;
    logic                   w_overrun;
`ifdef UART_RX_PARITY_EN
    logic                   w_par_smp;
    logic                   r_par_bad;
`endif

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sync  <= '1;
        end else begin
            r_state <= w_next;
            r_sync  <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    always_comb begin
        w_next = r_state;
        if (baud_tick) begin
            case (r_state)
                S_IDLE:  if (!w_rx_s) w_next = S_START;
                S_START: if (r_tick_cnt == TICK_MID) w_next = w_rx_s ? S_IDLE : S_DATA;
                S_DATA:  if (r_tick_cnt == TICK_LAST && r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                             w_next = parity_en ? S_PARITY : S_STOP;
`else
                             w_next = S_STOP;
`endif
                         end
`ifdef UART_RX_PARITY_EN
                S_PARITY: if (r_tick_cnt == TICK_LAST) w_next = S_STOP;
`endif
                S_STOP:  if (r_tick_cnt == TICK_LAST) w_next = w_rx_s ? S_IDLE : S_BREAK;
                S_BREAK: if (w_rx_s) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (r_state != S_IDLE);
        w_data_smp = baud_tick && (r_state == S_DATA) && (r_tick_cnt == TICK_LAST);
        w_stop_smp = baud_tick && (r_state == S_STOP) && (r_tick_cnt == TICK_LAST);
`ifdef UART_RX_PARITY_EN
        w_par_smp  = baud_tick && (r_state == S_PARITY) && (r_tick_cnt == TICK_LAST);
`endif
        // A consumer taking the old byte in the completion cycle frees the slot.
        w_load     = w_stop_smp && w_rx_s && (!rx_valid || rx_ready);
        w_overrun  = w_stop_smp && w_rx_s && rx_valid && !rx_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else if (baud_tick) begin
            if (r_state != w_next || r_state == S_IDLE || r_state == S_BREAK)
                r_tick_cnt <= '0;
            else
                r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TW'(1);
            if (r_state != S_DATA)
                r_bit_cnt <= '0;
            else if (w_data_smp)
                r_bit_cnt <= r_bit_cnt + BW'(1);
            if (w_data_smp)
                r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= w_stop_smp && !w_rx_s;
            overrun_err <= w_overrun;
            if (w_load) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bad  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= w_stop_smp && r_par_bad;
            if (r_state == S_IDLE)
                r_par_bad <= 1'b0;
            else if (w_par_smp)
                r_par_bad <= ((^r_shift) ^ w_rx_s) != parity_odd;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : directed self-checking bench for uart_rx, divisor 4 ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, busy, frame_err, overrun_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       parity_err;
`endif

    int tests = 0, fails = 0;
    int fe_cnt = 0, ov_cnt = 0, busy_cnt = 0, vld_rise = 0, pe_cnt = 0;
    int div_cnt = 0;
    int f0, o0, b0, v0, p0;
    logic vld_q = 1'b0;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_tick   (baud_tick),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .parity_err  (parity_err)
`endif
    );

    always #5 clk = ~clk;

    // One tick every 4 clocks -> 64 clocks per bit.
    initial forever begin
        @(negedge clk);
        div_cnt   = (div_cnt + 1) % 4;
        baud_tick = (div_cnt == 0);
    end

    always @(negedge clk) begin
        if (frame_err)   fe_cnt++;
        if (overrun_err) ov_cnt++;
        if (busy)        busy_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err)  pe_cnt++;
`endif
        if (rx_valid && !vld_q) vld_rise++;
        vld_q = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        f0 = fe_cnt; o0 = ov_cnt; b0 = busy_cnt; v0 = vld_rise; p0 = pe_cnt;
    endtask

    task automatic consume();
        @(negedge clk); rx_ready = 1'b1;
        @(negedge clk); rx_ready = 1'b0;
    endtask

    // Frame starts on the negedge right after a tick edge, so the stop bit
    // is sampled on the 612th posedge after rx falls (11-bit frames: 676th).
    task automatic send_frame(input logic [7:0] d, input logic stop, input int par,
                              input bit pulse_ready);
        logic [10:0] bits;
        int n;
        @(posedge clk);
        while (!baud_tick) @(posedge clk);
        @(negedge clk);
        bits = '0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        n = 9;
        if (par >= 0) begin bits[9] = par[0]; n = 10; end
        bits[n] = stop;
        n++;
        for (int b = 0; b < n; b++) begin
            rx = bits[b];
            for (int j = 1; j <= 64; j++) begin
                @(negedge clk);
                if (pulse_ready && b == n - 1) begin
                    if (j == 35) rx_ready = 1'b1;
                    if (j == 36) rx_ready = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_oerr", overrun_err, 0);
        rst_n = 1'b1;

        snap();
        repeat (1000) @(negedge clk);
        check("idle_busy_cycles", busy_cnt - b0, 0);
        check("idle_errs", (fe_cnt - f0) + (ov_cnt - o0) + (vld_rise - v0), 0);

        snap();
        send_frame(8'hA5, 1'b1, -1, 1'b0);
        check("a5_valid", rx_valid, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_ferr", fe_cnt - f0, 0);
        repeat (200) @(negedge clk);
        check("a5_hold_valid", rx_valid, 1);
        check("a5_hold_data", rx_data, 8'hA5);
        consume();
        check("a5_consumed", rx_valid, 0);

        snap();
        @(negedge clk); rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_busy_cycles", busy_cnt - b0, 32);
        check("glitch_busy_end", busy, 0);
        check("glitch_no_valid", vld_rise - v0, 0);
        check("glitch_no_err", (fe_cnt - f0) + (ov_cnt - o0), 0);

        snap();
        send_frame(8'h3C, 1'b0, -1, 1'b0);
        repeat (20 * 64) @(negedge clk);
        check("break_busy", busy, 1);
        check("break_ferr_pulses", fe_cnt - f0, 1);
        check("break_no_valid", vld_rise - v0, 0);
        rx = 1'b1;
        repeat (64) @(negedge clk);
        check("break_exit", busy, 0);
        send_frame(8'h5A, 1'b1, -1, 1'b0);
        check("after_break_valid", rx_valid, 1);
        check("after_break_data", rx_data, 8'h5A);
        check("after_break_ferr", fe_cnt - f0, 1);
        consume();

        snap();
        send_frame(8'h11, 1'b1, -1, 1'b0);
        send_frame(8'h22, 1'b1, -1, 1'b0);
        check("ovr_pulses", ov_cnt - o0, 1);
        check("ovr_data_kept", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1);
        consume();
        check("ovr_consumed", rx_valid, 0);

        send_frame(8'h11, 1'b1, -1, 1'b0);
        check("hs_first", rx_data, 8'h11);
        snap();
        send_frame(8'h22, 1'b1, -1, 1'b1);
        check("hs_data", rx_data, 8'h22);
        check("hs_valid", rx_valid, 1);
        check("hs_no_ovr", ov_cnt - o0, 0);
        consume();

        snap();
        @(negedge clk); rx = 1'b0;
        repeat (200) @(negedge clk);
        check("mid_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1 check("mid_reset_busy", busy, 0);
        rx = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("mid_no_err", (fe_cnt - f0) + (ov_cnt - o0), 0);
        check("mid_no_valid", rx_valid, 0);

`ifdef UART_RX_PARITY_EN
        parity_en = 1'b1; parity_odd = 1'b0;
        snap();
        send_frame(8'h07, 1'b1, 0, 1'b0);
        check("par_bad_pulse", pe_cnt - p0, 1);
        check("par_bad_data", rx_data, 8'h07);
        check("par_bad_valid", rx_valid, 1);
        consume();
        snap();
        send_frame(8'h07, 1'b1, 1, 1'b0);
        check("par_ok_pulse", pe_cnt - p0, 0);
        check("par_ok_data", rx_data, 8'h07);
        consume();
        parity_en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
